// File: rtl/alu_result_display_if.sv
// Bus between the ALU and the result display: load strobe and result in,
// conversion status and 7-segment drive out.
interface alu_result_display_if #(
  parameter int LENGTH_v = 5
);
  logic                    load;
  logic [LENGTH_v*2-1:0]   value;
  logic                    negative;
  logic                    busy;
  logic [3:0]              anode;
  logic [6:0]              segments;

  modport master (output load, value, negative, input busy, anode, segments);
  modport slave  (input load, value, negative, output busy, anode, segments);
endinterface

// File: rtl/alu_result_display.sv
// ALU result display: double-dabble binary-to-BCD converter with a one-deep
// pending buffer, feeding a 4-digit multiplexed active-low 7-segment scanner.
module alu_result_display #(
  parameter int LENGTH_v = 5,
  parameter int CLK_DIV  = 50000
) (
  input  logic                clock,
  input  logic                reset,
  alu_result_display_if.slave bus
);
  localparam int W  = LENGTH_v * 2;
  localparam int CW = $clog2(W + 1);
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [15:0]     bcd_q, bcd_d, adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            minus_q, minus_d;   // 1 = result is negative
  logic            pend_q, pend_d;
  logic [W-1:0]    pval_q, pval_d;
  logic            pminus_q, pminus_d;
  logic [15:0]     dbcd_q, dbcd_d;
  logic            dminus_q, dminus_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    minus_d  = minus_q;
    pend_d   = pend_q;
    pval_d   = pval_q;
    pminus_d = pminus_q;
    dbcd_d   = dbcd_q;
    dminus_d = dminus_q;
    case (state_q)
      IDLE: if (bus.load) begin
        shift_d = bus.value;
        minus_d = ~bus.negative;
        bcd_d   = '0;
        cnt_d   = CW'(W);
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = LATCH;
        if (bus.load) begin
          pend_d   = 1'b1;
          pval_d   = bus.value;
          pminus_d = ~bus.negative;
        end
      end
      LATCH: begin
        dbcd_d   = bcd_q;
        dminus_d = minus_q;
        state_d  = IDLE;
        // A load arriving now is newer than anything pending, so it wins.
        if (bus.load || pend_q) begin
          shift_d = bus.load ? bus.value : pval_q;
          minus_d = bus.load ? ~bus.negative : pminus_q;
          bcd_d   = '0;
          cnt_d   = CW'(W);
          pend_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      minus_q  <= 1'b0;
      pend_q   <= 1'b0;
      pval_q   <= '0;
      pminus_q <= 1'b0;
      dbcd_q   <= '0;
      dminus_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      minus_q  <= minus_d;
      pend_q   <= pend_d;
      pval_q   <= pval_d;
      pminus_q <= pminus_d;
      dbcd_q   <= dbcd_d;
      dminus_q <= dminus_d;
    end
  end

  assign bus.busy = (state_q != IDLE);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d, glyph;
  logic [3:0]    d0, d1, d2, d3;

  assign {d3, d2, d1, d0} = dbcd_q;

  // Leading-zero blanking; digit 3 doubles as sign / overflow indicator.
  always_comb begin
    glyph = SEG_BLANK;
    case (ptr_q)
      2'd0: glyph = seg7(d0);
      2'd1: glyph = ((d3 | d2 | d1) != 4'd0) ? seg7(d1) : SEG_BLANK;
      2'd2: glyph = ((d3 | d2) != 4'd0) ? seg7(d2) : SEG_BLANK;
      2'd3: if (d3 != 4'd0)                   glyph = dminus_q ? SEG_E : seg7(d3);
            else if (dminus_q && dbcd_q != '0) glyph = SEG_DASH;
      default: glyph = SEG_BLANK;
    endcase
  end

  always_comb begin
    pre_d   = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
    tick_d  = (pre_q == PRE_MAX);
    ptr_d   = ptr_q;
    anode_d = anode_q;
    seg_d   = seg_q;
    if (tick_q) begin
      ptr_d   = ptr_q + 2'd1;
      anode_d = ~(4'b0001 << ptr_q);
      seg_d   = glyph;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      ptr_q   <= '0;
      anode_q <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      ptr_q   <= ptr_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.anode    = anode_q;
  assign bus.segments = seg_q;
endmodule

// File: tb/tb_alu_result_display.sv
// Randomized and directed bench for alu_result_display against a decimal
// display model built from plain integer arithmetic.
module tb_alu_result_display;
  localparam int LV   = 5;
  localparam int CD   = 4;
  localparam int CONV = LV * 2 + 1;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] ECHR  = 7'b0000110;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_result_display_if #(.LENGTH_v(LV)) bus ();
  alu_result_display #(.LENGTH_v(LV), .CLK_DIV(CD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] obs [4];
  int anode_bad;
  bit watch9 = 0;
  bit saw9   = 0;

  always @(negedge clock)
    if (watch9 && bus.anode != 4'b1111 && bus.segments == 7'b0010000) saw9 = 1;

  function automatic logic [6:0] dseg(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected glyph at position pos (0 = rightmost) for a signed decimal readout.
  function automatic logic [6:0] exp_seg(input int mag, input bit minus, input int pos);
    int ndig, p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    ndig = (mag >= 1000) ? 4 : (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
    if (pos == 3 && mag >= 1000 && minus) return ECHR;
    if (pos < ndig) return dseg((mag / p) % 10);
    if (pos == 3 && minus && mag != 0) return DASH;
    return BLANK;
  endfunction

  task automatic do_load(input int v, input bit n);
    @(negedge clock);
    bus.load = 1'b1; bus.value = 10'(v); bus.negative = n;
    @(negedge clock);
    bus.load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clock);
    end
    if (n >= 300) begin
      errors++;
      $display("FAIL busy_timeout still busy after %0d cycles", n);
    end
  endtask

  task automatic collect();
    for (int p = 0; p < 4; p++) obs[p] = 'x;
    anode_bad = 0;
    repeat (4*CD + 3) @(negedge clock);
    repeat (4*CD) begin
      @(negedge clock);
      case (bus.anode)
        4'b1110: obs[0] = bus.segments;
        4'b1101: obs[1] = bus.segments;
        4'b1011: obs[2] = bus.segments;
        4'b0111: obs[3] = bus.segments;
        default: anode_bad++;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.load = 1'b0; bus.value = '0; bus.negative = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++;
    if (bus.anode !== 4'b1111) begin errors++; $display("FAIL reset_anode got %b exp 1111", bus.anode); end
    checks++;
    if (bus.segments !== BLANK) begin errors++; $display("FAIL reset_segments got %b exp %b", bus.segments, BLANK); end
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    reset = 1'b0;
    repeat (CD) @(negedge clock);
    checks++;
    if (bus.anode !== 4'b1111) begin errors++; $display("FAIL scan_prelit got %b exp 1111", bus.anode); end
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 1 : CD) @(negedge clock);
      ea = 4'b1111; ea[d] = 1'b0;
      checks++;
      if (bus.anode !== ea) begin errors++; $display("FAIL scan_anode%0d got %b exp %b", d, bus.anode, ea); end
      checks++;
      if (bus.segments !== exp_seg(0, 0, d))
        begin errors++; $display("FAIL scan_seg%0d got %b exp %b", d, bus.segments, exp_seg(0, 0, d)); end
    end
  endtask

  task automatic test_convert(input int v, input bit n);
    int cyc;
    do_load(v, n);
    wait_idle(cyc);
    checks++;
    if (cyc != CONV) begin errors++; $display("FAIL conv_busy v=%0d got %0d exp %0d", v, cyc, CONV); end
    collect();
    checks++;
    if (anode_bad != 0) begin errors++; $display("FAIL conv_anode v=%0d got %0d bad exp 0", v, anode_bad); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== exp_seg(v, !n, p))
        begin errors++; $display("FAIL conv_digit%0d v=%0d neg=%0b got %b exp %b", p, v, n, obs[p], exp_seg(v, !n, p)); end
    end
  endtask

  task automatic test_pending();
    int cyc;
    saw9 = 0; watch9 = 1;
    do_load(50, 1);
    @(negedge clock);
    bus.load = 1'b1; bus.value = 10'd999; bus.negative = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    @(negedge clock);
    bus.load = 1'b1; bus.value = 10'd5; bus.negative = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    wait_idle(cyc);
    cyc += 4;
    checks++;
    if (cyc != 2*CONV) begin errors++; $display("FAIL pend_busy got %0d exp %0d", cyc, 2*CONV); end
    collect();
    watch9 = 0;
    checks++;
    if (saw9) begin errors++; $display("FAIL pend_overwritten got 999 shown exp never"); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== exp_seg(5, 0, p))
        begin errors++; $display("FAIL pend_digit%0d got %b exp %b", p, obs[p], exp_seg(5, 0, p)); end
    end
  endtask

  task automatic test_random();
    repeat (8) test_convert(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    int hi;
    do_load(300, 0);
    bus.load = 1'b1; bus.value = 10'd600; bus.negative = 1'b0;
    @(negedge clock);
    bus.load = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++;
    if (bus.anode !== 4'b1111) begin errors++; $display("FAIL rstmid_anode got %b exp 1111", bus.anode); end
    @(negedge clock);
    reset = 1'b0;
    hi = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.busy === 1'b1) hi++;
    end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL rstmid_pending got %0d busy cycles exp 0", hi); end
    collect();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== exp_seg(0, 0, p))
        begin errors++; $display("FAIL rstmid_digit%0d got %b exp %b", p, obs[p], exp_seg(0, 0, p)); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert(256, 0);
    test_convert(1023, 1);
    test_convert(7, 1);
    test_pending();
    test_convert(1000, 0);
    test_convert(0, 0);
    test_convert(0, 1);
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end
endmodule
